// File: rtl/seq_multi.sv
// seq_multi: iterative shift-add unsigned multiplier, one multiplier bit per clock.
// A start pulse in IDLE captures a and b; the product appears on res with a
// one-cycle done pulse once the operation finishes, and res holds until the
// next completion.
// Optional build macro SEQ_MULTI_EARLY_TERM_EN: the operation also finishes as
// soon as no set multiplier bits remain, so latency follows the highest set bit of b.
module seq_multi #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);

  localparam int RW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [RW-1:0]    RW_ZERO  = {RW{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Partial product for one iteration: the shifted multiplicand when the
  // current multiplier bit is set, otherwise zero.
  function automatic logic [RW-1:0] partial_product(input logic [RW-1:0] mcand,
                                                    input logic          bit0);
    logic [RW-1:0] pp;
    if (bit0) begin
      pp = mcand;
    end else begin
      pp = RW_ZERO;
    end
    return pp;
  endfunction

  state_t           state_r;
  state_t           state_next_s;

  logic [RW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [RW-1:0]    acc_r;
  logic [CNT_W-1:0] count_r;

  logic [RW-1:0]    mcand_next_s;
  logic [WIDTH-1:0] mplier_next_s;
  logic [RW-1:0]    acc_next_s;
  logic [CNT_W-1:0] count_next_s;

  logic [RW-1:0]    acc_sum_s;
  logic             last_iter_s;
  logic             no_bits_left_s;
  logic             finish_s;

  logic             busy_r;
  logic             done_r;
  logic [RW-1:0]    res_r;
  logic             busy_next_s;
  logic             done_next_s;
  logic [RW-1:0]    res_next_s;

  // Iteration arithmetic and the finish condition for the current BUSY edge.
  always_comb begin
    acc_sum_s      = acc_r + partial_product(mcand_r, mplier_r[0]);
    last_iter_s    = (count_r == LAST_CNT);
    no_bits_left_s = (mplier_r[WIDTH-1:1] == W_ZERO[WIDTH-2:0]);
`ifdef SEQ_MULTI_EARLY_TERM_EN
    finish_s       = (state_r == BUSY) && (last_iter_s || no_bits_left_s);
`else
    finish_s       = (state_r == BUSY) && last_iter_s;
`endif
  end

  // FSM state register; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: accept start only in IDLE, leave BUSY on the finishing edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (finish_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs: next values for the registered busy/done/res.
  always_comb begin
    busy_next_s = busy_r;
    done_next_s = 1'b0;
    res_next_s  = res_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          busy_next_s = 1'b1;
        end else begin
          busy_next_s = 1'b0;
        end
      end
      BUSY: begin
        if (finish_s) begin
          busy_next_s = 1'b0;
          done_next_s = 1'b1;
          res_next_s  = acc_sum_s;
        end else begin
          busy_next_s = 1'b1;
        end
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Datapath next values: load operands on accept, shift-add while busy.
  always_comb begin
    mcand_next_s  = mcand_r;
    mplier_next_s = mplier_r;
    acc_next_s    = acc_r;
    count_next_s  = count_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          mcand_next_s  = {W_ZERO, a};
          mplier_next_s = b;
          acc_next_s    = RW_ZERO;
          count_next_s  = CNT_ZERO;
        end else begin
          mcand_next_s  = mcand_r;
        end
      end
      BUSY: begin
        acc_next_s    = acc_sum_s;
        mcand_next_s  = mcand_r << 1;
        mplier_next_s = mplier_r >> 1;
        count_next_s  = count_r + CNT_ONE;
      end
      default: begin
        count_next_s  = CNT_ZERO;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mcand_r  <= RW_ZERO;
      mplier_r <= W_ZERO;
      acc_r    <= RW_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      mcand_r  <= mcand_next_s;
      mplier_r <= mplier_next_s;
      acc_r    <= acc_next_s;
      count_r  <= count_next_s;
    end
  end

  // Output registers: busy level, one-cycle done pulse, held result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= RW_ZERO;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
      res_r  <= res_next_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign res  = res_r;

endmodule
